// File: rtl/dmem_controller.sv
// Data-memory arbiter: round-robin grant across LSU channels, one memory
// transaction in flight, response relayed back to the granted LSU.
//
// Handshake: a request is held valid by its LSU until it samples its ready
// pulse; the LSU drops valid one cycle later. The controller parks in
// RELEASE until that drop is seen, so a stale valid is never re-granted.
module dmem_controller #(
    parameter int NUM_CONSUMERS = 8,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,
    output logic [2:0]                         debug_state
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READ_WAIT  = 3'd1,
        S_WRITE_WAIT = 3'd2,
        S_RELAY      = 3'd3,
        S_RELEASE    = 3'd4
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant;
    logic                    served_read;
    logic [NUM_CONSUMERS-1:0] pending;
    logic                    found;
    logic [IDX_W-1:0]        sel;
    logic                    served_valid;

    logic [ADDR_BITS-1:0] rd_addr_a [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] wr_addr_a [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] wr_data_a [NUM_CONSUMERS];

    assign pending     = consumer_read_valid | consumer_write_valid;
    assign debug_state = state;

    // Unpack the flat per-LSU buses into arrays indexable by the grant.
    always_comb begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            rd_addr_a[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
            wr_addr_a[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
            wr_data_a[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Round-robin search: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_CONSUMERS)) begin
                sum = sum - (IDX_W+1)'(NUM_CONSUMERS);
            end
            idx = sum[IDX_W-1:0];
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // The valid that must drop before the granted LSU may be released.
    always_comb begin
        served_valid = served_read ? consumer_read_valid[grant] : consumer_write_valid[grant];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a read wins over a write on the same LSU.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    next_state = consumer_read_valid[sel] ? S_READ_WAIT : S_WRITE_WAIT;
                end
            end
            S_READ_WAIT:  if (mem_read_ready)  next_state = S_RELAY;
            S_WRITE_WAIT: if (mem_write_ready) next_state = S_RELAY;
            S_RELAY:      next_state = S_RELEASE;
            S_RELEASE:    if (!served_valid)   next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Registered outputs and datapath: latch request, relay response, advance pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr               <= '0;
            grant                <= '0;
            served_read          <= 1'b0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= sel;
                        if (consumer_read_valid[sel]) begin
                            served_read      <= 1'b1;
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= rd_addr_a[sel];
                        end else begin
                            served_read       <= 1'b0;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= wr_addr_a[sel];
                            mem_write_data    <= wr_data_a[sel];
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid             <= 1'b0;
                        consumer_read_ready[grant] <= 1'b1;
                        for (int i = 0; i < NUM_CONSUMERS; i++) begin
                            if (grant == IDX_W'(i)) begin
                                consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                            end
                        end
                    end
                end
                S_WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_write_valid             <= 1'b0;
                        consumer_write_ready[grant] <= 1'b1;
                    end
                end
                S_RELAY: begin
                    consumer_read_ready  <= '0;
                    consumer_write_ready <= '0;
                end
                S_RELEASE: begin
                    if (!served_valid) begin
                        rr_ptr <= (grant == IDX_W'(NUM_CONSUMERS-1)) ? '0 : grant + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: LSU and memory behaviour models, a scoreboard
// queue of expected transactions, a vector table and directed sequences.
module tb_dmem_controller;

    localparam int N  = 8;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int EXP_W = 29;   // {lsu[3:0], is_write, addr[7:0], data[15:0]}

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RWAIT   = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic              clk;
    logic              reset;
    logic [N-1:0]      consumer_read_valid;
    logic [N*AW-1:0]   consumer_read_address;
    logic [N-1:0]      consumer_read_ready;
    logic [N*DW-1:0]   consumer_read_data;
    logic [N-1:0]      consumer_write_valid;
    logic [N*AW-1:0]   consumer_write_address;
    logic [N*DW-1:0]   consumer_write_data;
    logic [N-1:0]      consumer_write_ready;
    logic              mem_read_valid;
    logic [AW-1:0]     mem_read_address;
    logic              mem_read_ready;
    logic [DW-1:0]     mem_read_data;
    logic              mem_write_valid;
    logic [AW-1:0]     mem_write_address;
    logic [DW-1:0]     mem_write_data;
    logic              mem_write_ready;
    logic [2:0]        debug_state;

    dmem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready),
        .debug_state            (debug_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and model state
    logic [EXP_W-1:0] exp_q[$];
    int               tests;
    int               fails;
    int               cycle;
    int               last_ready_cycle;
    logic [N-1:0]     prev_rdy;
    logic [N-1:0]     seen_ready;
    int               rd_cnt [N];
    int               wr_cnt [N];
    int               hold_extra [N];
    int               rcnt, wcnt, rdelay, wdelay;
    logic [DW-1:0]    preload [256];

    typedef struct {
        int          lsu;
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
        int          delay;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [EXP_W-1:0] pack(int lsu, bit is_wr, logic [7:0] a, logic [15:0] d);
        logic [3:0] l;
        l = 4'(lsu);
        return {l, is_wr, a, d};
    endfunction

    task automatic check(string name, bit ok, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic mem_accept_check(bit is_wr);
        logic [EXP_W-1:0] e;
        check("mem_access_expected", exp_q.size() != 0, 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("mem_kind", e[24] == is_wr, 32'(is_wr), 32'(e[24]));
            if (is_wr) begin
                check("mem_write_addr", mem_write_address == e[23:16], 32'(mem_write_address), 32'(e[23:16]));
                check("mem_write_data", mem_write_data == e[15:0], 32'(mem_write_data), 32'(e[15:0]));
            end else begin
                check("mem_read_addr", mem_read_address == e[23:16], 32'(mem_read_address), 32'(e[23:16]));
            end
        end
    endtask

    // One cycle: LSU models, scoreboard monitor, memory model (all at negedge).
    task automatic step();
        logic [N-1:0]     rdy;
        logic [EXP_W-1:0] e;
        @(negedge clk);
        cycle++;
        for (int i = 0; i < N; i++) begin
            if (rd_cnt[i] > 0) begin
                rd_cnt[i]--;
                if (rd_cnt[i] == 0) consumer_read_valid[i] = 1'b0;
            end
            if (wr_cnt[i] > 0) begin
                wr_cnt[i]--;
                if (wr_cnt[i] == 0) consumer_write_valid[i] = 1'b0;
            end
        end
        rdy = consumer_read_ready | consumer_write_ready;
        check("one_ready", $countones(rdy) <= 1, 32'(rdy), 0);
        check("ready_pulse", (rdy & prev_rdy) == '0, 32'(rdy & prev_rdy), 0);
        check("one_mem_valid", !(mem_read_valid && mem_write_valid), {mem_read_valid, mem_write_valid}, 0);
        prev_rdy = rdy;
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
                seen_ready[i]    = 1'b1;
                last_ready_cycle = cycle;
                if (consumer_read_ready[i]) rd_cnt[i] = 1 + hold_extra[i];
                else                        wr_cnt[i] = 1 + hold_extra[i];
                check("ready_expected", exp_q.size() != 0, 32'(i), 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ready_lsu", 32'(e[28:25]) == 32'(i), 32'(i), 32'(e[28:25]));
                    check("ready_kind", e[24] == consumer_write_ready[i], 32'(consumer_write_ready[i]), 32'(e[24]));
                    if (!e[24]) begin
                        check("read_data", consumer_read_data[i*DW +: DW] == e[15:0],
                              32'(consumer_read_data[i*DW +: DW]), 32'(e[15:0]));
                    end
                end
            end
        end
        if (mem_read_ready) begin
            mem_read_ready = 1'b0;
            rcnt = 0;
        end else if (mem_read_valid) begin
            rcnt++;
            if (rcnt >= rdelay) begin
                mem_read_ready = 1'b1;
                mem_read_data  = preload[mem_read_address];
                mem_accept_check(1'b0);
            end
        end else begin
            rcnt = 0;
        end
        if (mem_write_ready) begin
            mem_write_ready = 1'b0;
            wcnt = 0;
        end else if (mem_write_valid) begin
            wcnt++;
            if (wcnt >= wdelay) begin
                mem_write_ready = 1'b1;
                mem_accept_check(1'b1);
            end
        end else begin
            wcnt = 0;
        end
    endtask

    task automatic issue(int lsu, bit is_wr, logic [7:0] a, logic [15:0] d);
        if (is_wr) begin
            consumer_write_address[lsu*AW +: AW] = a;
            consumer_write_data[lsu*DW +: DW]    = d;
            consumer_write_valid[lsu]            = 1'b1;
        end else begin
            consumer_read_address[lsu*AW +: AW] = a;
            consumer_read_valid[lsu]            = 1'b1;
        end
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && debug_state == ST_IDLE &&
                 consumer_read_valid == '0 && consumer_write_valid == '0) && n < budget) begin
            step();
            n++;
        end
        check("done_timeout", n < budget, 32'(n), 32'(budget));
    endtask

    initial begin
        int issue_cycle;
        int n;
        tests = 0; fails = 0; cycle = 0; last_ready_cycle = 0;
        prev_rdy = '0; seen_ready = '0;
        rcnt = 0; wcnt = 0; rdelay = 1; wdelay = 1;
        for (int i = 0; i < N; i++) begin
            rd_cnt[i] = 0; wr_cnt[i] = 0; hold_extra[i] = 0;
        end
        for (int i = 0; i < 256; i++) preload[i] = DW'(i * 3 + 1);
        consumer_read_valid = '0;  consumer_read_address = '0;
        consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        reset = 1'b1;

        // Reset state
        step(); step();
        check("reset_outputs",
              {mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready} == '0,
              {mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}, 0);
        check("reset_read_data", consumer_read_data == '0, 32'(consumer_read_data[31:0]), 0);
        check("reset_state", debug_state == ST_IDLE, 32'(debug_state), 32'(ST_IDLE));
        reset = 1'b0;
        step();

        // Vector table: single transactions, last one on LSU7 leaves rr_ptr at 0
        vecs[0] = '{lsu: 2, is_wr: 1'b0, addr: 8'h10, data: 16'hBEEF, delay: 3, exp_addr: 8'h10, exp_data: 16'hBEEF};
        vecs[1] = '{lsu: 3, is_wr: 1'b1, addr: 8'h22, data: 16'h1234, delay: 2, exp_addr: 8'h22, exp_data: 16'h1234};
        vecs[2] = '{lsu: 0, is_wr: 1'b0, addr: 8'h00, data: 16'h0001, delay: 1, exp_addr: 8'h00, exp_data: 16'h0001};
        vecs[3] = '{lsu: 5, is_wr: 1'b1, addr: 8'hFF, data: 16'hFFFF, delay: 4, exp_addr: 8'hFF, exp_data: 16'hFFFF};
        vecs[4] = '{lsu: 7, is_wr: 1'b0, addr: 8'hFF, data: 16'h5A5A, delay: 1, exp_addr: 8'hFF, exp_data: 16'h5A5A};
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_wr) wdelay = vecs[v].delay;
            else begin
                rdelay = vecs[v].delay;
                preload[vecs[v].addr] = vecs[v].data;
            end
            exp_q.push_back(pack(vecs[v].lsu, vecs[v].is_wr, vecs[v].exp_addr, vecs[v].exp_data));
            issue(vecs[v].lsu, vecs[v].is_wr, vecs[v].addr, vecs[v].data);
            issue_cycle = cycle;
            wait_done(40);
            check("ready_latency", last_ready_cycle - issue_cycle == vecs[v].delay + 1,
                  32'(last_ready_cycle - issue_cycle), 32'(vecs[v].delay + 1));
            check("idle_latency", cycle - last_ready_cycle == 2, 32'(cycle - last_ready_cycle), 2);
        end
        check("read_data_hold2", consumer_read_data[2*DW +: DW] == 16'hBEEF, 32'(consumer_read_data[2*DW +: DW]), 32'hBEEF);
        check("read_data_hold0", consumer_read_data[0 +: DW] == 16'h0001, 32'(consumer_read_data[0 +: DW]), 32'h0001);

        // Simultaneous reads from 0, 1, 5 served in round-robin order
        rdelay = 2;
        preload[8'h30] = 16'hA000; preload[8'h31] = 16'hA001; preload[8'h35] = 16'hA005;
        exp_q.push_back(pack(0, 1'b0, 8'h30, 16'hA000));
        exp_q.push_back(pack(1, 1'b0, 8'h31, 16'hA001));
        exp_q.push_back(pack(5, 1'b0, 8'h35, 16'hA005));
        issue(0, 1'b0, 8'h30, 16'h0); issue(1, 1'b0, 8'h31, 16'h0); issue(5, 1'b0, 8'h35, 16'h0);
        wait_done(60);

        // Serve LSU6, then LSU7 and LSU0 together: 7 first, then wrap to 0
        preload[8'h36] = 16'hB006; preload[8'h37] = 16'hB007; preload[8'h38] = 16'hB000;
        exp_q.push_back(pack(6, 1'b0, 8'h36, 16'hB006));
        issue(6, 1'b0, 8'h36, 16'h0);
        wait_done(30);
        exp_q.push_back(pack(7, 1'b1, 8'h37, 16'hC007));
        exp_q.push_back(pack(0, 1'b0, 8'h38, 16'hB000));
        wdelay = 1;
        issue(7, 1'b1, 8'h37, 16'hC007); issue(0, 1'b0, 8'h38, 16'h0);
        wait_done(40);

        // Reset in READ_WAIT: grant 3 (rr_ptr=1) is abandoned, then 0 wins from rr_ptr=0
        rdelay = 30;
        preload[8'h40] = 16'hD000; preload[8'h43] = 16'hD003;
        exp_q.push_back(pack(3, 1'b0, 8'h43, 16'hD003));
        issue(0, 1'b0, 8'h40, 16'h0); issue(3, 1'b0, 8'h43, 16'h0);
        n = 0;
        while (debug_state != ST_RWAIT && n < 10) begin
            step();
            n++;
        end
        check("reach_read_wait", debug_state == ST_RWAIT, 32'(debug_state), 32'(ST_RWAIT));
        check("rw_addr_before_reset", mem_read_address == 8'h43, 32'(mem_read_address), 32'h43);
        #2 reset = 1'b1;
        #1;
        check("reset_drops_valid", mem_read_valid == 1'b0, 32'(mem_read_valid), 0);
        check("reset_drops_ready", (consumer_read_ready | consumer_write_ready) == '0,
              32'(consumer_read_ready | consumer_write_ready), 0);
        check("reset_state_mid", debug_state == ST_IDLE, 32'(debug_state), 32'(ST_IDLE));
        exp_q.delete();
        rdelay = 2;
        exp_q.push_back(pack(0, 1'b0, 8'h40, 16'hD000));
        exp_q.push_back(pack(3, 1'b0, 8'h43, 16'hD003));
        step();
        reset = 1'b0;
        wait_done(60);

        // LSU4 holds valid 3 cycles past its ready: controller parks in RELEASE
        hold_extra[4] = 3;
        preload[8'h44] = 16'hE004;
        seen_ready = '0;
        exp_q.push_back(pack(4, 1'b0, 8'h44, 16'hE004));
        issue(4, 1'b0, 8'h44, 16'h0);
        n = 0;
        while (!seen_ready[4] && n < 20) begin
            step();
            n++;
        end
        check("lsu4_ready_seen", seen_ready[4] == 1'b1, 32'(seen_ready[4]), 1);
        for (int j = 0; j < 4; j++) begin
            step();
            check("hold_in_release", debug_state == ST_RELEASE, 32'(debug_state), 32'(ST_RELEASE));
            check("hold_no_mem", !mem_read_valid && !mem_write_valid, {mem_read_valid, mem_write_valid}, 0);
        end
        wait_done(20);
        hold_extra[4] = 0;
        for (int j = 0; j < 5; j++) step();
        check("final_queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
